// File: rtl/sdf_bf2_stage16.sv
// Radix-2 SDF butterfly stage: sums of each 16-sample block, then the differences rotated by W16^k.
// Registered output one cycle after each accepted sample. in_valid=0 freezes the stage. SDF_ROUND_EN enables rounding of the multiply.
module sdf_bf2_stage16 #(
  parameter int DW    = 24,
  parameter int DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] din_r,
  input  logic signed [DW-1:0] din_i,
  input  logic signed [DW-1:0] w_r,
  input  logic signed [DW-1:0] w_i,
  output logic [2:0]           tw_idx,
  output logic                 out_valid,
  output logic signed [DW-1:0] dout_r,
  output logic signed [DW-1:0] dout_i
);

  localparam int PW = 2*DW + 1;

`ifdef SDF_ROUND_EN
  localparam logic signed [PW-1:0] RND = PW'(128);
`else
  localparam logic signed [PW-1:0] RND = '0;
`endif

  logic [3:0]           r_cnt;
  logic                 r_primed;
  logic signed [DW-1:0] r_dl_r [DEPTH];
  logic signed [DW-1:0] r_dl_i [DEPTH];

  logic                 w_phase_b;
  logic                 w_fire;
  logic signed [DW-1:0] w_hd_r, w_hd_i;
  logic signed [PW-1:0] w_ar, w_ai, w_tr, w_ti;
  logic signed [PW-1:0] w_pr, w_pi, w_pr_s, w_pi_s;
  logic signed [DW-1:0] w_mr, w_mi;
  logic signed [DW-1:0] w_sr, w_si, w_dr, w_di;
  logic signed [DW-1:0] w_push_r, w_push_i;
  logic signed [DW-1:0] w_out_r, w_out_i;
  logic                 w_unused;

  assign w_phase_b = r_cnt[3];
  assign w_fire    = in_valid & r_primed;
  assign tw_idx    = r_cnt[2:0];

  assign w_hd_r = r_dl_r[0];
  assign w_hd_i = r_dl_i[0];

  // Operands widened to the full product width so the difference of products cannot overflow.
  assign w_ar = {{(PW-DW){w_hd_r[DW-1]}}, w_hd_r};
  assign w_ai = {{(PW-DW){w_hd_i[DW-1]}}, w_hd_i};
  assign w_tr = {{(PW-DW){w_r[DW-1]}}, w_r};
  assign w_ti = {{(PW-DW){w_i[DW-1]}}, w_i};

  assign w_pr   = w_ar * w_tr - w_ai * w_ti;
  assign w_pi   = w_ar * w_ti + w_ai * w_tr;
  assign w_pr_s = (w_pr + RND) >>> 8;
  assign w_pi_s = (w_pi + RND) >>> 8;
  assign w_mr   = w_pr_s[DW-1:0];
  assign w_mi   = w_pi_s[DW-1:0];
  assign w_unused = ^{w_pr_s[PW-1:DW], w_pi_s[PW-1:DW]};

  assign w_sr = w_hd_r + din_r;
  assign w_si = w_hd_i + din_i;
  assign w_dr = w_hd_r - din_r;
  assign w_di = w_hd_i - din_i;

  assign w_push_r = w_phase_b ? w_dr : din_r;
  assign w_push_i = w_phase_b ? w_di : din_i;
  assign w_out_r  = w_phase_b ? w_sr : w_mr;
  assign w_out_i  = w_phase_b ? w_si : w_mi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_primed  <= 1'b0;
      out_valid <= 1'b0;
      dout_r    <= '0;
      dout_i    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_dl_r[i] <= '0;
        r_dl_i[i] <= '0;
      end
    end else begin
      out_valid <= w_fire;
      if (w_fire) begin
        dout_r <= w_out_r;
        dout_i <= w_out_i;
      end
      if (in_valid) begin
        r_cnt <= r_cnt + 4'd1;
        if (r_cnt == 4'd7)
          r_primed <= 1'b1;
        for (int i = 0; i < DEPTH-1; i++) begin
          r_dl_r[i] <= r_dl_r[i+1];
          r_dl_i[i] <= r_dl_i[i+1];
        end
        r_dl_r[DEPTH-1] <= w_push_r;
        r_dl_i[DEPTH-1] <= w_push_i;
      end
    end
  end

endmodule
